// File: rtl/mem_wb_stage.sv
// Purpose : MEM stage data-memory access plus the MEM/WB pipeline register.
// Latency : writeback registered one cycle after the completing edge; dmem request is combinational.
// Backpr. : mem_stall holds all upstream stages until dmem_resp; stalled edges load a bubble.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   exmem_*             instruction held in the EX/MEM register (stable while mem_stall=1)
//   dmem_*              single-outstanding data-memory handshake, one-cycle dmem_resp
//   mem_stall           freeze request to upstream stages
//   memwb_*, wb_*       regfile write port for the writeback stage
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        exmem_valid,
    input  logic        exmem_load_regfile,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_mem_read,
    input  logic        exmem_mem_write,
    input  logic [2:0]  exmem_funct3,
    input  logic [1:0]  exmem_regfilemux_sel,
    input  logic [31:0] exmem_alu_out,
    input  logic [31:0] exmem_rs2,
    input  logic [31:0] exmem_pc,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic        memwb_load_regfile,
    output logic [4:0]  memwb_rd,
    output logic [31:0] wb_regfilemux_out
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_mem_op;
    logic        w_rd_req;
    logic        w_wr_req;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;
    logic [31:0] w_wb_data;

    assign w_mem_op  = exmem_valid & (exmem_mem_read | exmem_mem_write);
    assign w_addr_lo = exmem_alu_out[1:0];

    // Requests are gated by rst so an access in flight disappears the moment
    // reset asserts; nothing remembers it, so it is never retried.
    // Read wins if the decoder ever flags both read and write.
    assign w_rd_req  = rst & w_mem_op & exmem_mem_read;
    assign w_wr_req  = rst & w_mem_op & exmem_mem_write & ~exmem_mem_read;

    assign dmem_read    = w_rd_req;
    assign dmem_write   = w_wr_req;
    assign dmem_address = {exmem_alu_out[31:2], 2'b00};
    assign mem_stall    = rst & w_mem_op & ~dmem_resp;

    // Store lane steering: data is moved onto the lanes the byte enables select.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        if (w_wr_req) begin
            case (exmem_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_addr_lo;
                    w_wdata = exmem_rs2 << {w_addr_lo, 3'b000};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {w_addr_lo[1], 1'b0};
                    w_wdata = exmem_rs2 << {w_addr_lo[1], 4'b0000};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = exmem_rs2;
                end
            endcase
        end
    end

    assign dmem_byte_enable = w_be;
    assign dmem_wdata       = w_wdata;

    // Load alignment and extension.
    always_comb begin
        case (w_addr_lo)
            2'b00:   w_ld_byte = dmem_rdata[7:0];
            2'b01:   w_ld_byte = dmem_rdata[15:8];
            2'b10:   w_ld_byte = dmem_rdata[23:16];
            default: w_ld_byte = dmem_rdata[31:24];
        endcase
        w_ld_half = w_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (exmem_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = {24'h0, w_ld_byte};
            3'b101:  w_ld_data = {16'h0, w_ld_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        case (exmem_regfilemux_sel)
            2'd1:    w_wb_data = w_ld_data;
            2'd2:    w_wb_data = exmem_pc + 32'd4;
            default: w_wb_data = exmem_alu_out;
        endcase
    end

    // Tracks whether an access is outstanding. A same-cycle response never
    // raises mem_stall, so it completes without visiting WAIT; a response with
    // no outstanding request leaves IDLE untouched.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (mem_stall) w_state_nxt = S_WAIT;
            S_WAIT:  if (dmem_resp) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // MEM/WB register. A stalled edge inserts a bubble but keeps rd/data so
    // the completing edge is the only one that produces a regfile write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memwb_load_regfile <= 1'b0;
            memwb_rd           <= 5'd0;
            wb_regfilemux_out  <= 32'h0;
        end else if (mem_stall) begin
            memwb_load_regfile <= 1'b0;
        end else begin
            memwb_load_regfile <= exmem_valid & exmem_load_regfile & (exmem_rd != 5'd0);
            memwb_rd           <= exmem_rd;
            wb_regfilemux_out  <= w_wb_data;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        exmem_valid;
    logic        exmem_load_regfile;
    logic [4:0]  exmem_rd;
    logic        exmem_mem_read;
    logic        exmem_mem_write;
    logic [2:0]  exmem_funct3;
    logic [1:0]  exmem_regfilemux_sel;
    logic [31:0] exmem_alu_out;
    logic [31:0] exmem_rs2;
    logic [31:0] exmem_pc;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_stall;
    logic        memwb_load_regfile;
    logic [4:0]  memwb_rd;
    logic [31:0] wb_regfilemux_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .exmem_valid          (exmem_valid),
        .exmem_load_regfile   (exmem_load_regfile),
        .exmem_rd             (exmem_rd),
        .exmem_mem_read       (exmem_mem_read),
        .exmem_mem_write      (exmem_mem_write),
        .exmem_funct3         (exmem_funct3),
        .exmem_regfilemux_sel (exmem_regfilemux_sel),
        .exmem_alu_out        (exmem_alu_out),
        .exmem_rs2            (exmem_rs2),
        .exmem_pc             (exmem_pc),
        .dmem_read            (dmem_read),
        .dmem_write           (dmem_write),
        .dmem_address         (dmem_address),
        .dmem_wdata           (dmem_wdata),
        .dmem_byte_enable     (dmem_byte_enable),
        .dmem_rdata           (dmem_rdata),
        .dmem_resp            (dmem_resp),
        .mem_stall            (mem_stall),
        .memwb_load_regfile   (memwb_load_regfile),
        .memwb_rd             (memwb_rd),
        .wb_regfilemux_out    (wb_regfilemux_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic ld, input logic [4:0] rd,
                          input logic rdf, input logic wrf, input logic [2:0] f3,
                          input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] pc);
        exmem_valid          = v;
        exmem_load_regfile   = ld;
        exmem_rd             = rd;
        exmem_mem_read       = rdf;
        exmem_mem_write      = wrf;
        exmem_funct3         = f3;
        exmem_regfilemux_sel = sel;
        exmem_alu_out        = alu;
        exmem_rs2            = rs2;
        exmem_pc             = pc;
    endtask

    // Load table: rdata = 0x80017F02.
    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
    logic [31:0] ld_adr [5] = '{32'h3000, 32'h3002, 32'h3001, 32'h3000, 32'h3003};
    logic [31:0] ld_exp [5] = '{32'h00000002, 32'hFFFF8001, 32'h0000007F, 32'h00007F02, 32'h80017F02};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        dmem_rdata = 32'h0;
        dmem_resp  = 1'b0;
        // A live load during reset must not reach memory.
        set_op(1, 1, 5'd3, 1, 0, 3'b010, 2'd1, 32'h40, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst_ld", {31'd0, memwb_load_regfile}, 32'd0);
        chk("rst_rd", {27'd0, memwb_rd}, 32'd0);
        chk("rst_data", wb_regfilemux_out, 32'd0);
        chk("rst_dread", {31'd0, dmem_read}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();

        // ALU op, rd=5; stray resp with no request is ignored.
        set_op(1, 1, 5'd5, 0, 0, 3'b000, 2'd0, 32'h1234, 32'h0, 32'h100);
        dmem_resp = 1'b1;
        #1;
        chk("alu_dread", {31'd0, dmem_read}, 32'd0);
        chk("alu_dwrite", {31'd0, dmem_write}, 32'd0);
        chk("alu_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        dmem_resp = 1'b0;
        chk("alu_ld", {31'd0, memwb_load_regfile}, 32'd1);
        chk("alu_rd", {27'd0, memwb_rd}, 32'd5);
        chk("alu_data", wb_regfilemux_out, 32'h00001234);

        // LB at 0x1003, response after three stalled cycles.
        set_op(1, 1, 5'd9, 1, 0, 3'b000, 2'd1, 32'h1003, 32'h0, 32'h104);
        #1;
        chk("lb_addr", dmem_address, 32'h1000);
        for (int i = 0; i < 3; i++) begin
            chk("lb_stall", {31'd0, mem_stall}, 32'd1);
            chk("lb_dread", {31'd0, dmem_read}, 32'd1);
            tick();
            chk("lb_bubble", {31'd0, memwb_load_regfile}, 32'd0);
        end
        dmem_rdata = 32'h80FF0000;
        dmem_resp  = 1'b1;
        #1;
        chk("lb_stall_done", {31'd0, mem_stall}, 32'd0);
        tick();
        dmem_resp = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lb_ld", {31'd0, memwb_load_regfile}, 32'd1);
        chk("lb_rd", {27'd0, memwb_rd}, 32'd9);
        chk("lb_data", wb_regfilemux_out, 32'hFFFFFF80);
        tick();
        chk("lb_once", {31'd0, memwb_load_regfile}, 32'd0);

        // SH at 0x2002, same-cycle response.
        set_op(1, 0, 5'd0, 0, 1, 3'b001, 2'd0, 32'h2002, 32'hDEADBEEF, 32'h108);
        dmem_resp = 1'b1;
        #1;
        chk("sh_be", {28'd0, dmem_byte_enable}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEF0000);
        chk("sh_dwrite", {31'd0, dmem_write}, 32'd1);
        chk("sh_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("sh_ld", {31'd0, memwb_load_regfile}, 32'd0);

        // SB lane 1 and SW.
        set_op(1, 0, 5'd0, 0, 1, 3'b000, 2'd0, 32'h2005, 32'h123456AB, 32'h10C);
        #1;
        chk("sb_be", {28'd0, dmem_byte_enable}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h3456AB00);
        set_op(1, 0, 5'd0, 0, 1, 3'b010, 2'd0, 32'h2007, 32'hCAFEF00D, 32'h10C);
        #1;
        chk("sw_be", {28'd0, dmem_byte_enable}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);
        chk("sw_addr", dmem_address, 32'h2004);

        // Both flags set: only the read goes out, no lanes.
        set_op(1, 1, 5'd4, 1, 1, 3'b010, 2'd1, 32'h2008, 32'hFFFFFFFF, 32'h110);
        #1;
        chk("both_dread", {31'd0, dmem_read}, 32'd1);
        chk("both_dwrite", {31'd0, dmem_write}, 32'd0);
        chk("both_be", {28'd0, dmem_byte_enable}, 32'd0);
        chk("both_wdata", dmem_wdata, 32'd0);
        tick();
        dmem_resp = 1'b0;

        // Invalid memory op: no request, no stall.
        set_op(0, 1, 5'd4, 1, 0, 3'b010, 2'd1, 32'h2008, 32'h0, 32'h110);
        #1;
        chk("inv_dread", {31'd0, dmem_read}, 32'd0);
        chk("inv_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("inv_ld", {31'd0, memwb_load_regfile}, 32'd0);

        // Load width/extension table, same-cycle responses.
        dmem_rdata = 32'h80017F02;
        dmem_resp  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_op(1, 1, 5'd7, 1, 0, ld_f3[i], 2'd1, ld_adr[i], 32'h0, 32'h200);
            tick();
            chk("ldtab_data", wb_regfilemux_out, ld_exp[i]);
        end
        dmem_resp = 1'b0;

        // JAL-style pc+4 wraps.
        set_op(1, 1, 5'd1, 0, 0, 3'b000, 2'd2, 32'h55, 32'h0, 32'hFFFFFFFC);
        tick();
        chk("jal_ld", {31'd0, memwb_load_regfile}, 32'd1);
        chk("jal_rd", {27'd0, memwb_rd}, 32'd1);
        chk("jal_data", wb_regfilemux_out, 32'h00000000);

        // rd=0 never writes; sel=3 selects alu_out.
        set_op(1, 1, 5'd0, 0, 0, 3'b000, 2'd3, 32'h777, 32'h0, 32'h300);
        tick();
        chk("rd0_ld", {31'd0, memwb_load_regfile}, 32'd0);
        chk("sel3_data", wb_regfilemux_out, 32'h777);

        // Commit something nonzero, then reset mid-WAIT of a LW.
        set_op(1, 1, 5'd12, 0, 0, 3'b000, 2'd0, 32'hABCD, 32'h0, 32'h304);
        tick();
        set_op(1, 1, 5'd13, 1, 0, 3'b010, 2'd1, 32'h4000, 32'h0, 32'h308);
        tick();
        chk("wait_stall", {31'd0, mem_stall}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_dread", {31'd0, dmem_read}, 32'd0);
        chk("mrst_stall", {31'd0, mem_stall}, 32'd0);
        chk("mrst_ld", {31'd0, memwb_load_regfile}, 32'd0);
        chk("mrst_rd", {27'd0, memwb_rd}, 32'd0);
        chk("mrst_data", wb_regfilemux_out, 32'd0);
        tick();
        set_op(1, 1, 5'd6, 0, 0, 3'b000, 2'd0, 32'h99, 32'h0, 32'h0);
        rst = 1'b1;
        // A stray response after reset must not disturb the idle FSM.
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        chk("post_ld", {31'd0, memwb_load_regfile}, 32'd1);
        chk("post_data", wb_regfilemux_out, 32'h99);
        // Fresh access after reset must stall normally (FSM back in IDLE).
        set_op(1, 1, 5'd8, 1, 0, 3'b010, 2'd1, 32'h5000, 32'h0, 32'h0);
        #1;
        chk("post_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        dmem_rdata = 32'h13579BDF;
        dmem_resp  = 1'b1;
        tick();
        dmem_resp = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_lw_ld", {31'd0, memwb_load_regfile}, 32'd1);
        chk("post_lw_data", wb_regfilemux_out, 32'h13579BDF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: `clk` (all state on rising edge) and `rst` (asserted low, takes effect without a clock edge).
REQ-002 SHALL expose these ports; `clk` and `rst` are listed first (name  direction  width  meaning):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `exmem_valid`  in  1  EX/MEM holds a live instruction.
- `exmem_load_regfile`  in  1  instruction writes rd.
- `exmem_rd`  in  5  destination register.
- `exmem_mem_read`  in  1  load.
- `exmem_mem_write`  in  1  store.
- `exmem_funct3`  in  3  access size/sign.
- `exmem_regfilemux_sel`  in  2  writeback source: 0 alu_out, 1 load data, 2 pc+4, 3 alu_out.
- `exmem_alu_out`  in  32  ALU result / effective address.
- `exmem_rs2`  in  32  store data.
- `exmem_pc`  in  32  instruction PC.
- `dmem_read`  out  1  data-memory read request.
- `dmem_write`  out  1  data-memory write request.
- `dmem_address`  out  32  word-aligned address.
- `dmem_wdata`  out  32  lane-shifted store data.
- `dmem_byte_enable`  out  4  store byte lanes.
- `dmem_rdata`  in  32  read data.
- `dmem_resp`  in  1  access complete, one cycle.
- `mem_stall`  out  1  freeze all upstream stages.
- `memwb_load_regfile`  out  1  regfile write enable.
- `memwb_rd`  out  5  regfile write index.
- `wb_regfilemux_out`  out  32  regfile write data.

Function
REQ-003 SHALL implement a two-state FSM (IDLE, WAIT); `mem_op` = `exmem_valid` & (`exmem_mem_read` | `exmem_mem_write`).
REQ-004 SHALL drive `dmem_read`/`dmem_write` combinationally from `exmem_mem_read`/`exmem_mem_write` whenever `mem_op`, in either state; otherwise drive both 0.
REQ-005 SHALL never assert `dmem_read` and `dmem_write` together; if both ex flags are set, only the read is issued.
REQ-006 SHALL drive `dmem_address` = {`exmem_alu_out[31:2]`, 2'b00}.
REQ-007 SHALL, for stores:
- SB: byte_enable = 4'b0001 << addr[1:0].
- SH: byte_enable = 4'b0011 << {addr[1],1'b0}.
- SW: byte_enable = 4'b1111.
- `dmem_wdata` = `exmem_rs2` shifted left by 8*(enabled lane offset).
- Lanes and data are 0 when no write is issued.
REQ-008 SHALL compute load data from `dmem_rdata` and addr:
- LB/LBU: byte addr[1:0].
- LH/LHU: halfword addr[1].
- LW: word; addr[1:0] ignored.
- Sign-extend LB/LH, zero-extend LBU/LHU.
- Other funct3 values treated as LW.
REQ-009 SHALL assert `mem_stall` = `mem_op` & ~`dmem_resp`, combinationally.
REQ-010 SHALL handle FSM transitions: IDLE→WAIT when `mem_stall`; WAIT→IDLE on `dmem_resp`; resp in the same cycle as the request completes in IDLE with no WAIT visit.
REQ-011 SHALL require `exmem_*` inputs to stay stable while `mem_stall`=1; behaviour otherwise is undefined.
REQ-012 SHALL update the MEM/WB register on each rising edge with `mem_stall`=0:
- `memwb_load_regfile` <= `exmem_valid` & `exmem_load_regfile` & (`exmem_rd`≠0).
- `memwb_rd` <= `exmem_rd`.
- `wb_regfilemux_out` <= selected source per REQ-002; pc+4 computed modulo 2^32.
REQ-013 SHALL, on an edge with `mem_stall`=1, load a bubble (`memwb_load_regfile` <= 0) and hold `memwb_rd` and `wb_regfilemux_out`, so each instruction writes back exactly once.
REQ-014 SHALL give writeback a latency of one cycle after the completing edge; a load with resp in cycle N writes the regfile in cycle N+1.
REQ-015 SHALL ignore `dmem_resp` when no request is outstanding.

Reset
REQ-016 SHALL, while `rst`=0, asynchronously force:
- FSM state IDLE.
- `memwb_load_regfile`=0, `memwb_rd`=0, `wb_regfilemux_out`=0.
REQ-017 SHALL, while `rst`=0, force `dmem_read`, `dmem_write`, `dmem_byte_enable` and `mem_stall` to 0, including reset asserted mid-WAIT; the aborted access is never retried.
REQ-018 SHALL resume normal operation on the first rising edge after `rst` returns to 1.

Verification
REQ-019 SHALL be verified by directed scenarios covering at least:
- ALU op, sel=0, rd=5, alu_out=0x1234 → next cycle load_regfile=1, rd=5, data=0x00001234, no dmem request.
- LB, addr=0x1003, rdata=0x80FF_0000, resp after 3 cycles → `mem_stall` high 3 cycles, address=0x1000, then data=0xFFFFFF80 written once.
- SH, addr=0x2002, rs2=0xDEADBEEF, resp same cycle → byte_enable=0b1100, wdata=0xBEEF0000, no stall, `memwb_load_regfile`=0.
- JAL-style sel=2, pc=0xFFFFFFFC, rd=1 → data=0x00000000.
- rd=0 writeback instruction → `memwb_load_regfile` stays 0.
- LW stalled in WAIT, `rst` pulsed low → `dmem_read` and `mem_stall` drop immediately, all memwb outputs 0, FSM IDLE.
